// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // Fetch unit side: issues requests, receives instruction words.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    // Memory side: observes requests, returns instruction words.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage for the single-cycle MIPS controller/datapath.
// Holds the PC, fetches over a req/ack bus, latches the instruction and
// strobes the controller's enable once per instruction. Next-PC follows
// the controller's pcsel; also tracks retired count and halt/fault status.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    pc_fetch_unit_if.master    imem,
    output logic [31:0]        instr,
    output logic               enable,
    input  logic [1:0]         pcsel,
    input  logic [31:0]        jr_target,
    input  logic               stall,
    input  logic               halt,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic [CNT_W-1:0]   instret,
    output logic               halted,
    output logic               addr_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'b00,
        SEL_BRANCH = 2'b01,
        SEL_JUMP   = 2'b10,
        SEL_JR     = 2'b11
    } pcsel_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] next_pc;
    logic [31:0] branch_off;
    logic        retire;
    logic        jr_misaligned;

    assign pc_plus4       = pc + 32'd4;
    assign branch_off     = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign imem.imem_addr = pc;

    // Retire happens on the single EXEC cycle where the datapath is ready.
    assign retire        = (state_q == ST_EXEC) && !stall;
    assign jr_misaligned = (pcsel_t'(pcsel) == SEL_JR) && (jr_target[1:0] != 2'b00);

    // Next-PC selection; only consumed on the retire edge.
    always_comb begin
        next_pc = pc_plus4;
        case (pcsel_t'(pcsel))
            SEL_SEQ:    next_pc = pc_plus4;
            SEL_BRANCH: next_pc = pc_plus4 + branch_off;
            SEL_JUMP:   next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
            SEL_JR:     next_pc = {jr_target[31:2], 2'b00};
            default:    next_pc = pc_plus4;
        endcase
    end

    // State register; async reset forces IDLE so req/enable drop at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake/strobe outputs.
    always_comb begin
        state_d       = state_q;
        imem.imem_req = 1'b0;
        enable        = 1'b0;
        halted        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem.imem_req = 1'b1;
                if (imem.imem_ack) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                enable = !stall;
                if (!stall) begin
                    state_d = halt ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Instruction latch: captured only on an acknowledged FETCH edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr <= '0;
        end else if ((state_q == ST_FETCH) && imem.imem_ack) begin
            instr <= imem.imem_rdata;
        end
    end

    // PC and retired-instruction counter advance together on retire.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= RESET_PC;
            instret <= '0;
        end else if (retire) begin
            pc      <= next_pc;
            instret <= instret + CNT_W'(1);
        end
    end

    // Sticky flag for a JR to a non-word-aligned target; execution continues.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_err <= 1'b0;
        end else if (retire && jr_misaligned) begin
            addr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed instruction stream with a memory model;
// expectations are queued at fetch time and checked at each enable strobe.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC   = 32'h0040_0000;
    localparam int unsigned TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                reset_n = 1'b1;
    logic [31:0]         instr;
    logic                enable;
    logic [1:0]          pcsel = 2'b00;
    logic [31:0]         jr_target = '0;
    logic                stall = 1'b0;
    logic                halt = 1'b0;
    logic [31:0]         pc;
    logic [31:0]         pc_plus4;
    logic [TB_CNT_W-1:0] instret;
    logic                halted;
    logic                addr_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          cnt;
        logic        err;
    } exp_t;

    exp_t sb[$];

    pc_fetch_unit_if imem_bus();

    pc_fetch_unit #(
        .RESET_PC (RST_PC),
        .CNT_W    (TB_CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .imem      (imem_bus),
        .instr     (instr),
        .enable    (enable),
        .pcsel     (pcsel),
        .jr_target (jr_target),
        .stall     (stall),
        .halt      (halt),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .instret   (instret),
        .halted    (halted),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every enable strobe must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && enable) begin
                if (sb.size() == 0) begin
                    check("unexpected_enable", 32'(enable), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("mon_pc",       pc,           e.pc);
                    check("mon_pc_plus4", pc_plus4,     e.pc + 32'd4);
                    check("mon_instr",    instr,        e.instr);
                    check("mon_instret",  32'(instret), 32'(e.cnt % (1 << TB_CNT_W)));
                    check("mon_addr_err", 32'(addr_err), 32'(e.err));
                end
            end
        end
    end

    // Fetch one instruction through the memory model and execute it.
    task automatic run_instr(input logic [31:0] exp_pc, input logic [31:0] word,
                             input int delay, input logic [1:0] sel,
                             input logic [31:0] jr, input int stalls,
                             input logic hlt, input int exp_cnt, input logic exp_err);
        int   n;
        exp_t e;
        n = 0;
        while (!imem_bus.imem_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!imem_bus.imem_req) begin
            check("req_timeout", 32'(imem_bus.imem_req), 32'd1);
            return;
        end
        check("imem_addr", imem_bus.imem_addr, exp_pc);
        imem_bus.imem_ack = 1'b0;
        repeat (delay) begin
            @(posedge clk); #1;
            check("req_held", 32'(imem_bus.imem_req), 32'd1);
        end
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = word;
        e.pc = exp_pc; e.instr = word; e.cnt = exp_cnt; e.err = exp_err;
        sb.push_back(e);
        @(posedge clk); #1;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'hBAD0_BAD0;
        check("req_drop", 32'(imem_bus.imem_req), 32'd0);
        pcsel     = sel;
        jr_target = jr;
        halt      = hlt;
        stall     = (stalls > 0);
        repeat (stalls) begin
            @(posedge clk); #1;
            check("stall_pc",      pc,           exp_pc);
            check("stall_instret", 32'(instret), 32'(exp_cnt % (1 << TB_CNT_W)));
        end
        stall = 1'b0;
        @(posedge clk); #1;
        pcsel = 2'b00;
        halt  = 1'b0;
        check("enable_once", 32'(enable), 32'd0);
    endtask

    // Stimulus.
    initial begin
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = '0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_req",      32'(imem_bus.imem_req), 32'd0);
        check("rst_enable",   32'(enable),   32'd0);
        check("rst_pc",       pc,            RST_PC);
        check("rst_pc_plus4", pc_plus4,      32'h0040_0004);
        check("rst_instr",    instr,         32'd0);
        check("rst_instret",  32'(instret),  32'd0);
        check("rst_halted",   32'(halted),   32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h2008_0005;
        check("idle_req", 32'(imem_bus.imem_req), 32'd0);
        @(posedge clk); #1;
        check("first_req", 32'(imem_bus.imem_req), 32'd1);

        run_instr(32'h0040_0000, 32'h2008_0005, 0, 2'b00, '0, 0, 1'b0, 0, 1'b0);
        check("i1_pc",      pc,           32'h0040_0004);
        check("i1_instret", 32'(instret), 32'd1);

        run_instr(32'h0040_0004, 32'h1000_0002, 0, 2'b01, '0, 0, 1'b0, 1, 1'b0);
        run_instr(32'h0040_0010, 32'h1000_FFFC, 1, 2'b01, '0, 0, 1'b0, 2, 1'b0);
        run_instr(32'h0040_0004, 32'h1000_0002, 0, 2'b01, '0, 0, 1'b0, 3, 1'b0);
        run_instr(32'h0040_0010, 32'h1000_0003, 0, 2'b01, '0, 0, 1'b0, 4, 1'b0);
        run_instr(32'h0040_0020, 32'h0810_0040, 0, 2'b10, '0, 0, 1'b0, 5, 1'b0);
        run_instr(32'h0040_0100, 32'h03E0_0008, 0, 2'b11, 32'h0040_0206, 0, 1'b0, 6, 1'b0);
        check("jr_addr_err", 32'(addr_err), 32'd1);
        run_instr(32'h0040_0204, 32'h0000_0020, 3, 2'b00, '0, 2, 1'b0, 7, 1'b1);
        for (int k = 0; k < 7; k++) begin
            run_instr(32'h0040_0208 + 32'(4 * k), 32'h0000_0000, k % 2, 2'b00, '0, 0, 1'b0, 8 + k, 1'b1);
        end
        run_instr(32'h0040_0224, 32'h0000_0000, 0, 2'b00, '0, 0, 1'b1, 15, 1'b1);

        check("halt_halted",   32'(halted),   32'd1);
        check("halt_instret",  32'(instret), 32'd0);
        check("halt_pc",       pc,            32'h0040_0228);
        check("halt_addr_err", 32'(addr_err), 32'd1);
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            check("halt_req",  32'(imem_bus.imem_req), 32'd0);
            check("halt_hold", pc, 32'h0040_0228);
        end
        imem_bus.imem_ack = 1'b0;

        reset_n = 1'b0;
        #1;
        check("rst2_halted",   32'(halted),   32'd0);
        check("rst2_addr_err", 32'(addr_err), 32'd0);
        check("rst2_pc",       pc,            RST_PC);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst2_req", 32'(imem_bus.imem_req), 32'd1);

        reset_n = 1'b0;
        #1;
        check("midfetch_req",    32'(imem_bus.imem_req), 32'd0);
        check("midfetch_enable", 32'(enable), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        imem_bus.imem_ack = 1'b0;
        check("ign_ack_instr", instr, 32'd0);
        check("ign_ack_pc",    pc,    RST_PC);
        check("ign_ack_req",   32'(imem_bus.imem_req), 32'd1);
        run_instr(RST_PC, 32'h2008_0005, 1, 2'b00, '0, 0, 1'b0, 0, 1'b0);
        check("restart_pc",      pc,           32'h0040_0004);
        check("restart_instret", 32'(instret), 32'd1);

        repeat (2) @(posedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so a stuck DUT still terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the single-cycle MIPS controller/datapath.
- Holds the PC and issues requests to instruction memory over a req/ack handshake. It latches the returned instruction and drives the controller's enable for exactly one cycle per instruction.
- Computes next-PC from the controller's pcsel (00 seq, 01 branch, 10 jump, 11 jr).
- Also provides pc+4 for JAL writeback, a retired-instruction counter, and halt/fault status.

Parameters:
RESET_PC  32'h0040_0000  PC value loaded on reset (word-aligned)
CNT_W  32  width of retired-instruction counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address (= pc while imem_req=1)
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  32  instruction word
instr  output  32  latched instruction, feeds decoder (op=instr[31:26], func=instr[5:0])
enable  output  1  one-cycle execute strobe to controller
pcsel  input  2  next-PC select from controller
jr_target  input  32  rs register value for JR
stall  input  1  datapath not ready; hold execute
halt  input  1  stop after the current instruction retires
pc  output  32  current PC
pc_plus4  output  32  pc + 4 (JAL link value)
instret  output  CNT_W  retired-instruction count
halted  output  1  unit in HALT state
addr_err  output  1  sticky: misaligned JR target seen

Behaviour:
- Reset (reset_n=0, async): state=IDLE, pc=RESET_PC, instr=0, instret=0, halted=0, addr_err=0. Outputs imem_req=0 and enable=0 immediately, not waiting for a clock edge.
- IDLE: imem_req=0 for exactly one cycle after reset release; any imem_ack here is ignored. Next state FETCH.
- FETCH: imem_req=1, imem_addr=pc. Memory latency is unbounded.
  - imem_ack=1 on the rising edge: instr<=imem_rdata, go to EXEC.
  - imem_ack=0: remain in FETCH.
- EXEC: imem_req=0, enable=~stall.
  - stall=1: remain in EXEC with pc, instr and instret held. enable is never asserted twice for one instruction.
  - stall=0 (retire edge): pc<=next_pc, instret<=instret+1 (wraps modulo 2^CNT_W). Go to HALT if halt=1, else FETCH.
  - halt is sampled only on the retire edge.
- HALT: imem_req=0, enable=0, halted=1, pc frozen. Exit only via reset.
- next_pc (combinational, 32-bit, carries discarded):
  - 00: pc+4.
  - 01: pc+4 + (sign-extended instr[15:0] << 2).
  - 10: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - 11: {jr_target[31:2], 2'b00}. If jr_target[1:0]!=0 on the retire edge, addr_err<=1 (sticky until reset) and execution continues.
- pcsel is only meaningful while enable=1; the unit ignores it in every other state.
- pc_plus4 = pc+4 at all times (combinational); wraps 32'hFFFF_FFFC -> 0.
- imem_addr = pc in every state; only qualified by imem_req.
- Throughput: at least 2 cycles per instruction (1 FETCH with immediate ack + 1 EXEC).

Test Plan:
- Reset release, imem acks the same cycle with 0x20080005 (addi): imem_req rises 1 cycle after reset_n high, addr 0x00400000. enable pulses for 1 cycle. Then pc=0x00400004 and instret=1.
- Branch: pc=0x00400010, instr imm=0xFFFC, pcsel=01 at enable -> pc=0x00400004. Same with imm=0x0003 -> pc=0x00400020.
- Jump/JR: instr=0x08100040, pcsel=10 -> pc=0x00400100. pcsel=11 with jr_target=0x00400206 -> pc=0x00400204 and addr_err=1 (stays 1 on later fetches).
- Handshake/stall: imem_ack delayed 3 cycles, then stall=1 for 2 cycles in EXEC. Expect imem_req high for 4 cycles, then enable=0 for 2 cycles, then enable=1 for exactly 1 cycle, with instret incremented exactly once.
- Halt and counter wrap: preload instret to 0xFFFFFFFF via a long run or a forced value, then halt=1 at the retire edge. Expect instret=0, halted=1, and imem_req held 0 for 10+ cycles.
- Reset mid-FETCH with imem_ack=1 arriving in the first IDLE cycle: the ack is ignored, instr=0, pc=RESET_PC, and the fetch restarts cleanly.
